// File: rtl/regfile_write_ctrl_pkg.sv
// rtl/regfile_write_ctrl_pkg.sv - shared types and sizes for the register-file write controller
package regfile_write_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int STARVE_W   = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// rtl/regfile_write_ctrl_if.sv - writeback, secondary and register-file port bundle
interface regfile_write_ctrl_if
  import regfile_write_ctrl_pkg::*;
#(
  parameter int XLEN = 32
);

  logic                  wb_we_i;
  logic [REG_ADDR_W-1:0] wb_addr_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  wb_stall_o;
  logic                  sec_req_i;
  logic [REG_ADDR_W-1:0] sec_addr_i;
  logic [XLEN-1:0]       sec_data_i;
  logic                  sec_ack_o;
  logic                  busy_o;
  logic                  rf_we_o;
  logic [REG_ADDR_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]       rf_wdata_o;

  modport slave (
    input  wb_we_i, wb_addr_i, wb_data_i, sec_req_i, sec_addr_i, sec_data_i,
    output wb_stall_o, sec_ack_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport master (
    output wb_we_i, wb_addr_i, wb_data_i, sec_req_i, sec_addr_i, sec_data_i,
    input  wb_stall_o, sec_ack_o, busy_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

endinterface

// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - register-file write-port arbiter with post-reset zeroing sweep
module regfile_write_ctrl
  import regfile_write_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int STARVE_LIMIT   = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_write_ctrl_if.slave bus
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;

  logic                  wb_stall;
  logic                  sec_ack;
  logic                  busy;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_idx_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      starve_q  <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    starve_d  = starve_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == REG_ADDR_W'(NUM_REGS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.wb_we_i && bus.sec_req_i) begin
          if (starve_q != '1) starve_d = starve_q + 1'b1;
          // Writeback still owns this cycle; the secondary path wins the next one.
          if (starve_q == STARVE_W'(STARVE_LIMIT)) state_d = ST_FORCE;
        end else begin
          starve_d = '0;
        end
      end
      ST_FORCE: begin
        state_d  = ST_RUN;
        starve_d = '0;
      end
      default: state_d = ST_RUN;
    endcase
    if (!bus.sec_req_i) starve_d = '0;
  end

  always_comb begin
    wb_stall = 1'b0;
    sec_ack  = 1'b0;
    busy     = (state_q == ST_CLEAR);
    rf_we    = 1'b0;
    rf_waddr = bus.wb_addr_i;
    rf_wdata = bus.wb_data_i;
    unique case (state_q)
      ST_CLEAR: begin
        rf_we    = 1'b1;
        rf_waddr = clr_idx_q;
        rf_wdata = '0;
        wb_stall = bus.wb_we_i;
      end
      ST_RUN: begin
        if (bus.wb_we_i) begin
          rf_we = (bus.wb_addr_i != '0);
        end else if (bus.sec_req_i) begin
          sec_ack  = 1'b1;
          rf_we    = (bus.sec_addr_i != '0);
          rf_waddr = bus.sec_addr_i;
          rf_wdata = bus.sec_data_i;
        end
      end
      ST_FORCE: begin
        wb_stall = bus.wb_we_i;
        if (bus.sec_req_i) begin
          sec_ack  = 1'b1;
          rf_we    = (bus.sec_addr_i != '0);
          rf_waddr = bus.sec_addr_i;
          rf_wdata = bus.sec_data_i;
        end
      end
      default: ;
    endcase
    // Nothing may reach the register file or the requesters while reset is held.
    if (rst) begin
      rf_we    = 1'b0;
      sec_ack  = 1'b0;
      wb_stall = 1'b0;
    end
  end

  assign bus.wb_stall_o = wb_stall;
  assign bus.sec_ack_o  = sec_ack;
  assign bus.busy_o     = busy;
  assign bus.rf_we_o    = rf_we;
  assign bus.rf_waddr_o = rf_waddr;
  assign bus.rf_wdata_o = rf_wdata;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb/tb_regfile_write_ctrl.sv - randomized self-checking bench for regfile_write_ctrl
module tb_regfile_write_ctrl;
  import regfile_write_ctrl_pkg::*;

  localparam int LIMIT   = 4;
  localparam int B_BUSY  = 40;
  localparam int B_STALL = 39;
  localparam int B_ACK   = 38;
  localparam int B_WE    = 37;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic preload = 1'b0;

  int n_checks  = 0;
  int n_errors  = 0;
  int sweep_idx = NUM_REGS;
  int denied    = 0;

  logic [31:0] rf     [NUM_REGS];
  logic [31:0] ref_rf [NUM_REGS];
  logic [40:0] exp_vec;
  logic [40:0] obs_vec;

  regfile_write_ctrl_if #(.XLEN(32)) bus ();

  regfile_write_ctrl #(
    .XLEN(32),
    .STARVE_LIMIT(LIMIT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the distributed-RAM register file.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'hDEADBEEF;
    end else if (bus.rf_we_o) begin
      rf[bus.rf_waddr_o] <= bus.rf_wdata_o;
    end
  end

  // One clock from a falling edge to the next; the model decides who owns the port:
  // the sweep first, then the secondary if writeback is idle or it has waited LIMIT+1 denials.
  task automatic run_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic sr, input logic [4:0] sa, input logic [31:0] sd);
    logic sec_wins;
    sec_wins = 1'b0;
    bus.wb_we_i    = we;
    bus.wb_addr_i  = wa;
    bus.wb_data_i  = wd;
    bus.sec_req_i  = sr;
    bus.sec_addr_i = sa;
    bus.sec_data_i = sd;
    if (sweep_idx < NUM_REGS) begin
      exp_vec = {1'b1, we, 1'b0, 1'b1, 5'(sweep_idx), 32'h0};
    end else begin
      sec_wins = sr && (!we || denied == LIMIT + 1);
      if (sec_wins) exp_vec = {1'b0, we, 1'b1, sa != 5'd0, sa, sd};
      else          exp_vec = {1'b0, 1'b0, 1'b0, we && (wa != 5'd0), wa, wd};
    end
    #2;
    obs_vec = {bus.busy_o, bus.wb_stall_o, bus.sec_ack_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o};
    @(negedge clk);
    if (sweep_idx < NUM_REGS) begin
      ref_rf[sweep_idx] = 32'h0;
      sweep_idx++;
    end else if (sec_wins) begin
      if (sa != 5'd0) ref_rf[sa] = sd;
      denied = 0;
    end else begin
      if (we && wa != 5'd0) ref_rf[wa] = wd;
      denied = sr ? denied + 1 : 0;
    end
  endtask

  task automatic test_reset();
    bus.wb_we_i    = 1'b1;
    bus.wb_addr_i  = 5'd3;
    bus.wb_data_i  = '1;
    bus.sec_req_i  = 1'b0;
    bus.sec_addr_i = '0;
    bus.sec_data_i = '0;
    preload = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = 32'hDEADBEEF;
    @(negedge clk);
    preload = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({bus.busy_o, bus.wb_stall_o, bus.sec_ack_o, bus.rf_we_o} !== 4'b1000) begin
        n_errors++;
        $display("FAIL reset_outputs busy/stall/ack/we got %b expected 1000",
                 {bus.busy_o, bus.wb_stall_o, bus.sec_ack_o, bus.rf_we_o});
      end
      @(negedge clk);
    end
    rst       = 1'b0;
    sweep_idx = 0;
    denied    = 0;
  endtask

  task automatic test_clear_sweep();
    int busy_cnt  = 0;
    int first_low = -1;
    for (int k = 0; k < 34; k++) begin
      run_cycle((k < 32) ? 1'($urandom) : 1'b0, 5'($urandom), $urandom, 1'b0, 5'd0, 32'd0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL sweep cycle %0d got %h expected %h", k, obs_vec, exp_vec);
      end
      if (obs_vec[B_BUSY]) busy_cnt++;
      else if (first_low < 0) first_low = k;
    end
    n_checks++;
    if (busy_cnt != 32) begin
      n_errors++;
      $display("FAIL sweep_busy_len got %0d expected 32", busy_cnt);
    end
    n_checks++;
    if (first_low != 32) begin
      n_errors++;
      $display("FAIL sweep_busy_fall got cycle %0d expected 32", first_low);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      n_checks++;
      if (rf[i] !== 32'h0) begin
        n_errors++;
        $display("FAIL sweep_zero x%0d got %h expected 0", i, rf[i]);
      end
    end
  endtask

  task automatic test_wb_write();
    run_cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL wb_write_port got %h expected %h", obs_vec, exp_vec);
    end
    n_checks++;
    if (rf[5] !== 32'h1234) begin
      n_errors++;
      $display("FAIL wb_write_x5 got %h expected 00001234", rf[5]);
    end
  endtask

  task automatic test_sec_write();
    run_cycle(1'b0, 5'd2, 32'h0, 1'b1, 5'd7, 32'hA5A5A5A5);
    n_checks++;
    if (obs_vec !== exp_vec || obs_vec[B_ACK] !== 1'b1) begin
      n_errors++;
      $display("FAIL sec_write_port got %h expected %h", obs_vec, exp_vec);
    end
    run_cycle(1'b0, 5'd2, 32'h0, 1'b0, 5'd7, 32'hA5A5A5A5);
    n_checks++;
    if (obs_vec[B_ACK] !== 1'b0) begin
      n_errors++;
      $display("FAIL sec_ack_pulse got %b expected 0", obs_vec[B_ACK]);
    end
    n_checks++;
    if (rf[7] !== 32'hA5A5A5A5) begin
      n_errors++;
      $display("FAIL sec_write_x7 got %h expected a5a5a5a5", rf[7]);
    end
  endtask

  task automatic test_starve();
    int   ack_cycle = -1;
    logic stall_at_ack = 1'b0;
    for (int k = 1; k <= 20 && ack_cycle < 0; k++) begin
      run_cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'd9, 32'hC0FFEE09);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL starve cycle %0d got %h expected %h", k, obs_vec, exp_vec);
      end
      if (obs_vec[B_ACK]) begin
        ack_cycle    = k;
        stall_at_ack = obs_vec[B_STALL];
      end
    end
    n_checks++;
    if (ack_cycle != LIMIT + 2 || stall_at_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL starve_latency got cycle %0d stall %b expected cycle %0d stall 1",
               ack_cycle, stall_at_ack, LIMIT + 2);
    end
    run_cycle(1'b1, 5'd3, 32'h77, 1'b0, 5'd9, 32'h0);
    n_checks++;
    if (obs_vec[B_WE] !== 1'b1 || obs_vec[B_STALL] !== 1'b0 || rf[3] !== 32'h77 || rf[9] !== 32'hC0FFEE09) begin
      n_errors++;
      $display("FAIL starve_resume got we %b stall %b x3 %h x9 %h expected 1 0 00000077 c0ffee09",
               obs_vec[B_WE], obs_vec[B_STALL], rf[3], rf[9]);
    end
  endtask

  task automatic test_x0();
    run_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (obs_vec !== exp_vec || obs_vec[B_WE] !== 1'b0) begin
      n_errors++;
      $display("FAIL x0_wb got %h expected %h", obs_vec, exp_vec);
    end
    run_cycle(1'b0, 5'd1, 32'd0, 1'b1, 5'd0, 32'h12345678);
    n_checks++;
    if (obs_vec !== exp_vec || obs_vec[B_WE] !== 1'b0 || obs_vec[B_ACK] !== 1'b1) begin
      n_errors++;
      $display("FAIL x0_sec got %h expected %h", obs_vec, exp_vec);
    end
    n_checks++;
    if (rf[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL x0_value got %h expected 0", rf[0]);
    end
  endtask

  task automatic test_random();
    logic        pend = 1'b0;
    logic [4:0]  pa   = '0;
    logic [31:0] pd   = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pa   = 5'($urandom);
        pd   = $urandom;
      end
      run_cycle($urandom_range(0, 9) < 7, 5'($urandom), $urandom, pend, pa, pd);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random cycle %0d got %h expected %h", k, obs_vec, exp_vec);
      end
      if (exp_vec[B_ACK]) pend = 1'b0;
    end
    run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      n_checks++;
      if (rf[i] !== ref_rf[i]) begin
        n_errors++;
        $display("FAIL random_rf x%0d got %h expected %h", i, rf[i], ref_rf[i]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt = 0;
    rst = 1'b1;
    sweep_idx = 0;
    denied    = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL midsweep_pre cycle %0d got %h expected %h", k, obs_vec, exp_vec);
      end
    end
    bus.wb_we_i = 1'b1;
    rst       = 1'b1;
    sweep_idx = 0;
    denied    = 0;
    #2;
    n_checks++;
    if ({bus.busy_o, bus.wb_stall_o, bus.sec_ack_o, bus.rf_we_o} !== 4'b1000) begin
      n_errors++;
      $display("FAIL midsweep_reset busy/stall/ack/we got %b expected 1000",
               {bus.busy_o, bus.wb_stall_o, bus.sec_ack_o, bus.rf_we_o});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 34; k++) begin
      run_cycle(1'($urandom), 5'($urandom), $urandom, 1'b0, 5'd0, 32'd0);
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL midsweep_post cycle %0d got %h expected %h", k, obs_vec, exp_vec);
      end
      if (obs_vec[B_BUSY]) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 32) begin
      n_errors++;
      $display("FAIL midsweep_busy_len got %0d expected 32", busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_wb_write();
    test_sec_write();
    test_starve();
    test_x0();
    test_random();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the core's 32×32 distributed-RAM register file. It zeroes every register after reset and arbitrates the single write port between two requesters: the pipeline writeback stage (priority) and a secondary debug/late-load return path (valid/ack handshake). A bounded starvation counter protects the secondary path. It sits between the writeback stage and the register file's `we`/`write_addr`/`data_i` inputs.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `STARVE_LIMIT`, 8, consecutive denied cycles before the secondary requester is forced through (1..255).
- `CLEAR_ON_RESET`, 1, 1 = run the zeroing sweep after reset; 0 = start directly in RUN.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_we_i`  in  1  writeback write request.
- `wb_addr_i`  in  5  writeback destination register.
- `wb_data_i`  in  XLEN  writeback data.
- `wb_stall_o`  out  1  writeback must hold its request this cycle; it is not written.
- `sec_req_i`  in  1  secondary write request; held with address and data stable until acked.
- `sec_addr_i`  in  5  secondary destination register.
- `sec_data_i`  in  XLEN  secondary data.
- `sec_ack_o`  out  1  one-cycle grant pulse; the request is consumed at this clock edge.
- `busy_o`  out  1  clear sweep in progress; the pipeline must not issue.
- `rf_we_o`  out  1  to register-file `we`.
- `rf_waddr_o`  out  5  to register-file `write_addr`.
- `rf_wdata_o`  out  XLEN  to register-file `data_i`.

## Operation
- States: CLEAR, RUN, FORCE. Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
- CLEAR:
  - A 5-bit counter `clr_idx` starts at 0. Each cycle drives `rf_we_o`=1, `rf_waddr_o`=`clr_idx`, `rf_wdata_o`=0.
  - At `clr_idx`=31 it moves to RUN.
  - `busy_o`=1. `wb_stall_o`=1 if `wb_we_i`. `sec_ack_o`=0.
- RUN:
  - If `wb_we_i`, writeback is granted. A pending secondary request is denied and `starve_cnt` increments.
  - Otherwise a pending secondary request is granted: `sec_ack_o`=1 and `starve_cnt` is cleared.
  - If both requests are present and `starve_cnt`=`STARVE_LIMIT`, the next state is FORCE (writeback is still granted this cycle).
- FORCE:
  - Secondary is granted and `wb_stall_o`=`wb_we_i`. Returns to RUN with `starve_cnt` cleared.
  - If `sec_req_i`=0 in FORCE, there is no write and no ack; return to RUN.
- x0 protection: a granted write (either source) to address 0 drives `rf_we_o`=0. A secondary write to x0 is still acked. The CLEAR sweep does write x0.
- `starve_cnt` is 8 bits and saturates. It is cleared whenever `sec_req_i`=0.
- `rf_waddr_o`/`rf_wdata_o` follow the granted source. When there is no grant, they follow the writeback inputs.

## Timing
- All outputs are combinational from state and inputs; there is no added write latency. A granted write lands at the same clock edge as its request.
- Reset values: state CLEAR (or RUN), `clr_idx`=0, `starve_cnt`=0.
  - During reset: `busy_o`=`CLEAR_ON_RESET`, `rf_we_o`=0, `sec_ack_o`=0, `wb_stall_o`=0.
- With `CLEAR_ON_RESET`=1, `busy_o` is high for exactly 32 cycles after reset release and falls in cycle 32.
- Reset asserted mid-sweep restarts the sweep at index 0. Reset during FORCE abandons the forced grant without ack.
- Worst-case secondary latency under continuous writeback: `STARVE_LIMIT`+2 cycles from `sec_req_i` rising to `sec_ack_o`.
- Simultaneous same-address writes never occur: exactly one source is granted per cycle.

## Structure
- Shared core package:
  - state enum (CLEAR/RUN/FORCE);
  - `REG_ADDR_W`=5;
  - `NUM_REGS`=32.
- Single flat module with no sub-module. The register file itself stays a separate instance wired to the `rf_*` outputs.

## Test plan
- Reset release with `CLEAR_ON_RESET`=1, register file preloaded with 0xDEADBEEF -> addresses 0..31 written with 0 in order; `busy_o` drops at cycle 32; all reads return 0.
- RUN with `wb_we_i`=1, addr 5, data 0x1234 and `sec_req_i`=0 -> `rf_we_o`=1, addr 5, data 0x1234 the same cycle; x5 reads 0x1234 the next cycle.
- Secondary request (addr 7, 0xA5A5A5A5) with writeback idle -> `sec_ack_o` pulses for one cycle; x7=0xA5A5A5A5.
- `wb_we_i` held high continuously with `sec_req_i` high, `STARVE_LIMIT`=4 -> ack arrives on cycle 6 with `wb_stall_o`=1 in that cycle; writeback proceeds the following cycle.
- Writeback to x0 with data 0xFFFFFFFF, then secondary to x0 -> `rf_we_o`=0 for both, secondary still acked, x0 reads 0.
- Reset asserted at sweep index 12 -> after release the sweep restarts at 0 and `busy_o` is high for a full 32 cycles.
